// File: rtl/i2s_transmitter.sv
// I2S serializer: one stereo pair per 64-BCLK frame, BCLK/LRCLK divided from the audio clock, one-entry holding register.
// Optional build macro I2S_UNDERRUN_HOLD_EN: on underrun, replay the previous pair instead of emitting silence.
module i2s_transmitter #(
  parameter int AUDIO_BIT_WIDTH = 24,
  parameter int SLOT_WIDTH      = 32,
  parameter int MCLK_PER_BCLK   = 6
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [AUDIO_BIT_WIDTH-1:0] i_sample_left,
  input  logic [AUDIO_BIT_WIDTH-1:0] i_sample_right,
  input  logic                       i_sample_valid,
  output logic                       o_sample_ready,
  output logic                       o_bclk,
  output logic                       o_lrclk,
  output logic                       o_sdata,
  output logic                       o_underrun
);

  localparam int DW = $clog2(MCLK_PER_BCLK);
  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam logic [DW-1:0] D_LAST = DW'(MCLK_PER_BCLK - 1);
  localparam logic [DW-1:0] D_HALF = DW'(MCLK_PER_BCLK / 2);
  localparam logic [BW-1:0] B_LAST = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] B_SLOT = BW'(SLOT_WIDTH);

  logic [DW-1:0]              r_d;
  logic [BW-1:0]              r_b;
  logic                       r_bclk, r_lrclk, r_sdata, r_underrun;
  logic                       r_sample_ready;
  logic                       r_first;
  logic [AUDIO_BIT_WIDTH-1:0] r_hold_l, r_hold_r;
  logic [AUDIO_BIT_WIDTH-1:0] r_shift_l, r_shift_r;

  logic                       w_f, w_load, w_lr_next, w_bit;
  logic [DW-1:0]              w_d_next;
  logic [BW-1:0]              w_b_next, w_p_next;
  logic [AUDIO_BIT_WIDTH-1:0] w_word;

  assign w_f       = (r_d == D_LAST);
  assign w_d_next  = w_f ? '0 : r_d + DW'(1);
  assign w_load    = w_f && (r_b == B_LAST);
  assign w_b_next  = !w_f ? r_b : (w_load ? '0 : r_b + BW'(1));
  assign w_lr_next = (w_b_next >= B_SLOT);
  assign w_p_next  = w_lr_next ? w_b_next - B_SLOT : w_b_next;
  assign w_word    = w_lr_next ? r_shift_r : r_shift_l;

  // Slot position p carries sample bit [AUDIO_BIT_WIDTH-p]; p=0 is the one-BCLK I2S delay.
  always_comb begin
    w_bit = 1'b0;
    for (int i = 1; i <= AUDIO_BIT_WIDTH; i++) begin
      if (w_p_next == BW'(i)) w_bit = w_word[AUDIO_BIT_WIDTH-i];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_d            <= '0;
      r_b            <= '0;
      r_bclk         <= 1'b0;
      r_lrclk        <= 1'b0;
      r_sdata        <= 1'b0;
      r_underrun     <= 1'b0;
      r_sample_ready <= 1'b1;
      r_first        <= 1'b1;
      r_hold_l       <= '0;
      r_hold_r       <= '0;
      r_shift_l      <= '0;
      r_shift_r      <= '0;
    end else begin
      r_d        <= w_d_next;
      r_b        <= w_b_next;
      r_bclk     <= (w_d_next >= D_HALF);
      r_underrun <= 1'b0;
      if (w_f) begin
        r_lrclk <= w_lr_next;
        r_sdata <= w_bit;
      end
      if (w_load) begin
        r_first <= 1'b0;
        if (!r_sample_ready) begin
          r_shift_l      <= r_hold_l;
          r_shift_r      <= r_hold_r;
          r_sample_ready <= 1'b1;
        end else begin
          r_underrun <= !r_first;
`ifdef I2S_UNDERRUN_HOLD_EN
          r_shift_l <= r_shift_l;
          r_shift_r <= r_shift_r;
`else
          r_shift_l <= '0;
          r_shift_r <= '0;
`endif
        end
      end
      // A pair accepted on the load edge itself waits in holding for the next frame.
      if (i_sample_valid && r_sample_ready) begin
        r_hold_l       <= i_sample_left;
        r_hold_r       <= i_sample_right;
        r_sample_ready <= 1'b0;
      end
    end
  end

  assign o_sample_ready = r_sample_ready;
  assign o_bclk         = r_bclk;
  assign o_lrclk        = r_lrclk;
  assign o_sdata        = r_sdata;
  assign o_underrun     = r_underrun;

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serializes stereo 24-bit audio samples from the synthesizer's generation pipeline into a standard I2S stream for the audio codec DAC. Runs entirely on the 16.9344 MHz audio clock and derives BCLK (64·fs = 2.8224 MHz) and LRCLK (fs = 44.1 kHz) from it. Accepts one stereo sample per frame through a valid/ready handshake backed by a one-entry holding register, and flags underruns when no sample is available at a frame boundary.

## Interface

- AUDIO_BIT_WIDTH, 24, sample width; MSB-first, two's complement
- SLOT_WIDTH, 32, bits per channel slot; must be ≥ AUDIO_BIT_WIDTH+1
- MCLK_PER_BCLK, 6, audio clocks per BCLK period; even, ≥ 2 (16.9344 MHz / 2.8224 MHz)

- clock  in  1  audio clock, 16.9344 MHz, single clock domain
- reset  in  1  synchronous, active-high
- sample_left  in  AUDIO_BIT_WIDTH  left-channel sample
- sample_right  in  AUDIO_BIT_WIDTH  right-channel sample
- sample_valid  in  1  sample pair present
- sample_ready  out  1  holding register empty; transfer on valid && ready
- bclk  out  1  I2S bit clock
- lrclk  out  1  I2S word select; 0 = left, 1 = right
- sdata  out  1  I2S serial data
- underrun  out  1  one-cycle pulse: frame started with holding register empty

## Operation

- Divider d counts 0..MCLK_PER_BCLK-1, wraps. bclk = 1 iff d ≥ MCLK_PER_BCLK/2.
- Falling-edge event F: the cycle where d wraps to 0. Bit counter b (0..2·SLOT_WIDTH-1) advances at each F, wrapping.
- lrclk = 1 iff b ≥ SLOT_WIDTH. With p = b mod SLOT_WIDTH: sdata = sample bit [AUDIO_BIT_WIDTH-p] for 1 ≤ p ≤ AUDIO_BIT_WIDTH, else 0 (standard I2S one-BCLK delay after lrclk edge; unused LSB-side bits zero).
- Frame load: at the F where b wraps 2·SLOT_WIDTH-1 → 0, the holding register, if full, moves into the left/right shift registers and empties.
- Holding register empty at frame load → underrun pulses that cycle; shift contents per Configuration.
- sample_ready = holding register empty. Accept at any cycle with valid && ready; holding becomes full next cycle.
- Accept and frame load in the same cycle with holding empty: underrun is declared; accepted pair stays in holding for the next frame (no bypass).

## Timing

- Reset values: d=0, b=0, bclk=0, lrclk=0, sdata=0, sample_ready=1, underrun=0, holding empty, shift registers zero.
- All outputs registered; bclk, lrclk, sdata change only on clock edges; lrclk and sdata change only at F (BCLK falling), stable across the BCLK rising edge.
- BCLK period = MCLK_PER_BCLK cycles; frame = 2·SLOT_WIDTH·MCLK_PER_BCLK = 384 cycles → exactly 44.1 kHz.
- First frame after reset outputs zeros; underrun suppressed for the first frame load after reset only.
- Latency: pair accepted before frame load L appears at sdata starting SLOT_WIDTH... specifically MSB at the F one bit after L (MCLK_PER_BCLK cycles after L).
- Reset asserted mid-frame: all state returns to reset values the following cycle; holding and in-flight samples discarded; stream restarts at b=0.

## Configuration

- I2S_UNDERRUN_HOLD_EN defined: on underrun the shift registers reload the previous frame's pair (sample-and-hold, avoids clicks).
- Undefined: on underrun the shift registers load zero (silence).
- underrun pulse behaves identically in both builds.

## Test plan

- Reset, then observe 768 cycles -> bclk period 6 cycles (3 low, 3 high), lrclk toggles every 192 cycles, sdata=0, underrun never pulses in first frame.
- Hold sample_valid high with left=24'hA5A5A5, right=24'h5A5A5A -> sdata carries A5A5A5 MSB-first in left slot bits 1..24, 5A5A5A in right slot bits 33..56, zeros elsewhere; sample_ready deasserts after accept, reasserts one cycle after frame load.
- Stop sample_valid after one pair 24'h800001/24'h7FFFFF -> next frame load pulses underrun for exactly one cycle; sdata repeats 800001/7FFFFF with I2S_UNDERRUN_HOLD_EN, all zeros without.
- Assert sample_valid first in the frame-load cycle with holding empty -> underrun pulses, pair accepted, pair output in the following frame.
- Assert reset at b=40 mid right slot -> next cycle bclk=lrclk=sdata=0, sample_ready=1, holding cleared, next frame starts 384 cycles later with zeros.
- Stream 100 random pairs at full rate -> bit-exact recovery by a reference I2S receiver model, zero underrun pulses after first frame.
